data_sram_responder: RTL and testbench
======================================

Name: data_sram_responder

Overview:
- Responder end of the data-SRAM interface driven by the CPU core: en/we[3:0]/addr/wdata in, rdata out one cycle later.
- Backs the interface with an internal byte-writable word RAM.
- Also provides a small memory-mapped I/O window: LED, switch, timer, scratch.
- Sits beside the CPU in the SoC top and replaces the bare block-RAM so programs can observe time and drive outputs.

Parameters:
- RAM_AW, 12, RAM word-address width (2^RAM_AW words; 16 KiB at default).
- IO_BASE, 32'hBFAF_0000, base of the I/O window.
- IO_MASK, 32'hFFFF_0000, mask; an address is I/O iff (addr & IO_MASK) == IO_BASE.

Ports:
- clk  input  1  clock, all state on rising edge.
- resetn  input  1  reset, asynchronous, active-low.
- en  input  1  access request this cycle.
- we  input  4  byte write enables; 0 = read.
- addr  input  32  byte address; bits [1:0] ignored.
- wdata  input  32  write data, lane i = wdata[8i+7:8i].
- rdata  output  32  read data for the access accepted on the previous edge.
- switch_in  input  8  external switches, sampled.
- led_out  output  16  LED register value.

Behaviour:
- Every cycle with en=1 is accepted; there is no back-pressure. Read latency is exactly 1 cycle.
- Registered select: on an edge with en=1, latch is_io and io_offset (addr[7:2]). rdata is muxed from RAM output or the I/O read register using the latched select.
- With en=0, rdata holds its last value. The RAM output register and the I/O read register are not updated.
- RAM region (non-I/O):
  - Word index = addr[RAM_AW+1:2]; upper bits are ignored, so addresses alias and wrap.
  - Write: each lane with we[i]=1 is updated on the edge.
  - Read-first: an access with we!=0 still returns the old word on rdata next cycle.
  - RAM contents are not reset.
- I/O register map (offset = addr[15:0]):
  - 0x0000 LED: RW, bits [15:0], byte lanes 0–1 honoured, upper read 0.
  - 0x0004 SWITCH: RO, {24'b0, switch_in sync}.
  - 0x0008 TIMER: RW 32-bit. Increments by 1 every cycle and wraps 0xFFFF_FFFF→0. A write on a cycle replaces the enabled lanes with wdata and suppresses the increment that cycle.
  - 0x000C SCRATCH: RW 32-bit, byte lanes honoured.
  - Any other offset reads 0; writes are ignored.
- I/O reads are read-first: they return the value before any same-edge write, i.e. for TIMER the pre-increment value at the accepting edge.
- switch_in passes through a 2-flop synchroniser; SWITCH reads the synchronised value.
- Reset (asynchronous, any time, including mid-access):
  - Cleared to 0: rdata, led_out, TIMER, SCRATCH, synchroniser flops, latched select.
  - An access accepted on the edge before reset assertion is discarded, and rdata reads 0 after reset.
  - First access is accepted on the first edge with resetn=1.

Optional Feature:
- Macro DSR_ACCESS_CNT_EN.
- Defined: I/O offset 0x0010 ACCESS_CNT, RO 32-bit. Counts accepted cycles (en=1, either region), wraps, and resets to 0. A read returns the count excluding the reading access itself.
- Undefined: counter logic is absent and offset 0x0010 reads 0 like any unmapped offset.

Decomposition:
- Package dsr_pkg: IO offsets (LED, SWITCH, TIMER, SCRATCH, ACCESS_CNT), default IO_BASE/IO_MASK, and a byte-lane merge function (old word, new word, we → merged word).
- Sub-module sram_byte_ram: synchronous single-port RAM with 4 byte enables and registered read-first output.
- The top of data_sram_responder holds the decode, I/O registers, timer, synchroniser and output mux.

Test Plan:
- Write/read RAM: write 0xDEADBEEF to 0x0000_0100 (we=4'hF), then read 0x0000_0100 → rdata=0xDEADBEEF on the following cycle.
- Byte lanes: preload 0x11223344; write we=4'b0101, wdata=0xAABBCCDD → read returns 0x11BB33DD. A same-cycle read-first access returns 0x11223344.
- Timer: after reset, idle 10 cycles, then read 0xBFAF_0008 → 10 (±0, checked against the cycle count from deassertion). Write 0xFFFF_FFFF, then read 2 cycles later → 0x0000_0000 (wrap).
- LED/SWITCH/unmapped:
  - Write LED 0xFFFF_1234 → led_out=0x1234 next cycle.
  - switch_in=0xA5 → SWITCH read returns 0xA5 from the third edge after the change.
  - Read 0xBFAF_0040 → 0.
- Reset mid-access: issue a read of 0x100 (holding 0xCAFE0000), then assert resetn=0 before the next edge → rdata=0 immediately, led_out=0, TIMER=0. RAM still returns 0xCAFE0000 after reset.
- DSR_ACCESS_CNT_EN:
  - With the macro: 5 accepted accesses, then read 0xBFAF_0010 → 5.
  - Without the macro: the same read → 0.

Source files
------------

// File: rtl/dsr_pkg.sv
// dsr_pkg: shared I/O offsets, default I/O window and byte-lane merge helper for data_sram_responder
package dsr_pkg;
  localparam logic [31:0] DSR_IO_BASE    = 32'hBFAF_0000;
  localparam logic [31:0] DSR_IO_MASK    = 32'hFFFF_0000;
  localparam logic [15:0] OFF_LED        = 16'h0000;
  localparam logic [15:0] OFF_SWITCH     = 16'h0004;
  localparam logic [15:0] OFF_TIMER      = 16'h0008;
  localparam logic [15:0] OFF_SCRATCH    = 16'h000C;
  localparam logic [15:0] OFF_ACCESS_CNT = 16'h0010;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] we);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = we[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/sram_byte_ram.sv
// sram_byte_ram: single-port word RAM with byte enables and registered read-first output
module sram_byte_ram #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];

  // contents are never reset; each enabled lane is written on the edge
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (en && we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];

  // read-first output register, holds while idle, cleared by reset
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rdata <= '0;
    else if (en) rdata <= mem[addr];
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: data-SRAM responder with RAM plus LED/SWITCH/TIMER/SCRATCH I/O window; DSR_ACCESS_CNT_EN adds ACCESS_CNT at 0x0010
module data_sram_responder
  import dsr_pkg::*;
#(
  parameter int          RAM_AW  = 12,
  parameter logic [31:0] IO_BASE = DSR_IO_BASE,
  parameter logic [31:0] IO_MASK = DSR_IO_MASK
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led_out
);
  logic        is_io, sel_io, io_wr;
  logic [15:0] off, led;
  logic [31:0] ram_q, io_q, io_rd, cnt_rd, timer, scratch;
  logic [7:0]  sw_s1, sw_s2;

  assign is_io   = (addr & IO_MASK) == IO_BASE;
  assign off     = addr[15:0] & ~16'h0003;
  assign io_wr   = en && is_io && (we != 4'h0);
  assign led_out = led;
  assign rdata   = sel_io ? io_q : ram_q;

  sram_byte_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .resetn(resetn),
    .en    (en && !is_io),
    .we    (we),
    .addr  (addr[RAM_AW+1:2]),
    .wdata (wdata),
    .rdata (ram_q)
  );

`ifdef DSR_ACCESS_CNT_EN
  logic [31:0] acc_cnt;

  // counts every accepted cycle in either region; read value excludes the reading access
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) acc_cnt <= '0;
    else if (en) acc_cnt <= acc_cnt + 32'd1;

  assign cnt_rd = (off == OFF_ACCESS_CNT) ? acc_cnt : '0;
`else
  assign cnt_rd = '0;
`endif

  assign io_rd = (off == OFF_LED)     ? {16'h0, led}   :
                 (off == OFF_SWITCH)  ? {24'h0, sw_s2} :
                 (off == OFF_TIMER)   ? timer          :
                 (off == OFF_SCRATCH) ? scratch        : cnt_rd;

  // latch the region select and the pre-write I/O value of each accepted access
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sel_io <= 1'b0;
      io_q   <= '0;
    end else if (en) begin
      sel_io <= is_io;
      io_q   <= io_rd;
    end

  // I/O registers; a timer write replaces the increment for that cycle
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      led     <= '0;
      scratch <= '0;
      timer   <= '0;
    end else begin
      if (io_wr && off == OFF_LED)
        led <= {we[1] ? wdata[15:8] : led[15:8], we[0] ? wdata[7:0] : led[7:0]};
      if (io_wr && off == OFF_SCRATCH) scratch <= merge_lanes(scratch, wdata, we);
      timer <= (io_wr && off == OFF_TIMER) ? merge_lanes(timer, wdata, we) : timer + 32'd1;
    end

  // two-flop synchroniser for the external switches
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switch_in;
      sw_s2 <= sw_s1;
    end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: table-driven and sequence checks for data_sram_responder
module tb_data_sram_responder;
  logic        clk, resetn, en;
  logic [3:0]  we;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  switch_in;
  logic [15:0] led_out;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp_rd;
    logic [15:0] exp_led;
  } vec_t;

  vec_t v[20];

  data_sram_responder dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .switch_in(switch_in),
    .led_out  (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e;
    we = w;
    addr = a;
    wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    en = 1'b0;
    we = 4'h0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    logic [31:0] exp_cnt;
    v[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF, 1'b0, 32'h0,         16'h0000};
    v[1]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'h0000};
    v[2]  = '{1'b1, 4'hF, 32'h0000_0200, 32'h1122_3344, 1'b0, 32'h0,         16'h0000};
    v[3]  = '{1'b1, 4'h5, 32'h0000_0200, 32'hAABB_CCDD, 1'b1, 32'h1122_3344, 16'h0000};
    v[4]  = '{1'b1, 4'h0, 32'h0000_0200, 32'h0,         1'b1, 32'h11BB_33DD, 16'h0000};
    v[5]  = '{1'b1, 4'h0, 32'h0000_4103, 32'h0,         1'b1, 32'hDEAD_BEEF, 16'h0000};
    v[6]  = '{1'b1, 4'hF, 32'hBFAF_0000, 32'hFFFF_1234, 1'b1, 32'h0,         16'h1234};
    v[7]  = '{1'b1, 4'h0, 32'hBFAF_0000, 32'h0,         1'b1, 32'h0000_1234, 16'h1234};
    v[8]  = '{1'b1, 4'hC, 32'hBFAF_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_1234, 16'h1234};
    v[9]  = '{1'b1, 4'h2, 32'hBFAF_0002, 32'h0000_AB00, 1'b1, 32'h0000_1234, 16'hAB34};
    v[10] = '{1'b1, 4'hF, 32'hBFAF_000C, 32'h0102_0304, 1'b1, 32'h0,         16'hAB34};
    v[11] = '{1'b1, 4'h2, 32'hBFAF_000C, 32'h0000_AA00, 1'b1, 32'h0102_0304, 16'hAB34};
    v[12] = '{1'b1, 4'h0, 32'hBFAF_000C, 32'h0,         1'b1, 32'h0102_AA04, 16'hAB34};
    v[13] = '{1'b0, 4'hF, 32'hBFAF_000C, 32'hFFFF_FFFF, 1'b1, 32'h0102_AA04, 16'hAB34};
    v[14] = '{1'b1, 4'h0, 32'hBFAF_000C, 32'h0,         1'b1, 32'h0102_AA04, 16'hAB34};
    v[15] = '{1'b1, 4'hF, 32'hBFAF_0040, 32'h1234_5678, 1'b1, 32'h0,         16'hAB34};
    v[16] = '{1'b1, 4'h0, 32'hBFAF_0040, 32'h0,         1'b1, 32'h0,         16'hAB34};
    v[17] = '{1'b1, 4'hF, 32'hBFAE_0004, 32'h0000_0055, 1'b0, 32'h0,         16'hAB34};
    v[18] = '{1'b1, 4'h0, 32'h0000_0004, 32'h0,         1'b1, 32'h0000_0055, 16'hAB34};
    v[19] = '{1'b1, 4'h0, 32'hBFAF_0004, 32'h0,         1'b1, 32'h0,         16'hAB34};

    resetn = 1'b0;
    en = 1'b0;
    we = 4'h0;
    addr = '0;
    wdata = '0;
    switch_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset rdata", rdata, 32'h0);
    check("reset led", {16'h0, led_out}, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc(v[i].en, v[i].we, v[i].addr, v[i].wdata);
      if (v[i].chk) check($sformatf("vec%0d rdata", i), rdata, v[i].exp_rd);
      check($sformatf("vec%0d led", i), {16'h0, led_out}, {16'h0, v[i].exp_led});
    end

    switch_in = 8'hA5;
    cyc(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
    check("switch edge1", rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
    check("switch edge2", rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'hBFAF_0004, 32'h0);
    check("switch edge3", rdata, 32'h0000_00A5);

    cyc(1'b1, 4'hF, 32'h0000_0100, 32'hCAFE_0000);
    cyc(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("pre-reset ram", rdata, 32'hCAFE_0000);
    en = 1'b1;
    we = 4'h0;
    addr = 32'h0000_0100;
    #2 resetn = 1'b0;
    #1;
    check("mid-reset rdata", rdata, 32'h0);
    check("mid-reset led", {16'h0, led_out}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    cyc(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    check("post-reset timer", rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'hBFAF_000C, 32'h0);
    check("post-reset scratch", rdata, 32'h0);
    cyc(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    check("post-reset ram kept", rdata, 32'hCAFE_0000);

    do_reset();
    repeat (10) cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    check("timer after 10 idle", rdata, 32'd10);
    cyc(1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFF);
    check("timer write read-first", rdata, 32'd11);
    cyc(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    check("timer written", rdata, 32'hFFFF_FFFF);
    cyc(1'b1, 4'h0, 32'hBFAF_0008, 32'h0);
    check("timer wrap", rdata, 32'h0);

    do_reset();
    repeat (5) cyc(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    cyc(1'b1, 4'h0, 32'hBFAF_0010, 32'h0);
`ifdef DSR_ACCESS_CNT_EN
    exp_cnt = 32'd5;
`else
    exp_cnt = 32'd0;
`endif
    check("access count", rdata, exp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
